// File: rtl/gf256_inv_sched_if.sv
// Request/result bundle between the two requesters and the shared GF(256) inverter.
interface gf256_inv_sched_if;
  logic [1:0] req;
  logic [7:0] x0;
  logic [7:0] x1;
  logic [1:0] gnt;
  logic       busy;
  logic       valid;
  logic       tag;
  logic [7:0] y;
  logic       zero;

  modport master (
    output req, x0, x1,
    input  gnt, busy, valid, tag, y, zero
  );

  modport slave (
    input  req, x0, x1,
    output gnt, busy, valid, tag, y, zero
  );
endinterface

// File: rtl/gf256_inv_sched.sv
// Shared GF(256) inverter: y = x^254 by seven square-and-multiply steps on one multiplier,
// with round-robin (or fixed-priority) arbitration between two tagged requesters.

module gf256_mult (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);
  logic [7:0] a_sh;

  // Shift-and-add, reducing by x^8+x^4+x^3+x^2+1 each time a is doubled.
  always_comb begin
    p    = 8'h00;
    a_sh = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a_sh;
      a_sh = {a_sh[6:0], 1'b0} ^ (a_sh[7] ? 8'h1D : 8'h00);
    end
  end
endmodule

// state | meaning
// IDLE  | waiting for a request; grant is driven combinationally here
// SQ    | sq <= sq*sq
// MUL   | acc <= acc*sq; on step 7 the product is the result
module gf256_inv_sched #(
  parameter bit RR = 1'b1
) (
  input logic              clk,
  input logic              rst,
  gf256_inv_sched_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ   = 2'd1,
    MUL  = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] sq;
  logic [7:0] acc;
  logic [2:0] step;
  logic       owner;
  logic       last;
  logic       zero_op;

  logic       busy_q;
  logic       valid_q;
  logic       tag_q;
  logic [7:0] y_q;
  logic       zero_q;

  logic       win;
  logic       req_any;
  logic [7:0] x_win;
  logic [7:0] mul_a;
  logic [7:0] prod;

  assign req_any = |bus.req;

  // On a tie the round-robin variant favours whoever was not served last.
  always_comb begin
    win = 1'b0;
    if (bus.req == 2'b10)
      win = 1'b1;
    else if (bus.req == 2'b11 && RR)
      win = ~last;
  end

  assign x_win   = win ? bus.x1 : bus.x0;
  assign bus.gnt = (state == IDLE && req_any && !rst) ? (win ? 2'b10 : 2'b01) : 2'b00;

  assign mul_a = (state == MUL) ? acc : sq;

  gf256_mult u_mult (
    .a (mul_a),
    .b (sq),
    .p (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sq      <= 8'h00;
      acc     <= 8'h00;
      step    <= 3'd0;
      owner   <= 1'b0;
      last    <= 1'b1;
      zero_op <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      tag_q   <= 1'b0;
      y_q     <= 8'h00;
      zero_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            sq      <= x_win;
            acc     <= 8'h01;
            step    <= 3'd1;
            owner   <= win;
            last    <= win;
            zero_op <= (x_win == 8'h00);
            busy_q  <= 1'b1;
            state   <= SQ;
          end
        end
        SQ: begin
          sq    <= prod;
          state <= MUL;
        end
        MUL: begin
          if (step == 3'd7) begin
            y_q     <= prod;
            valid_q <= 1'b1;
            tag_q   <= owner;
            zero_q  <= zero_op;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end else begin
            acc   <= prod;
            step  <= step + 3'd1;
            state <= SQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.tag   = tag_q;
  assign bus.y     = y_q;
  assign bus.zero  = zero_q;
endmodule

// File: tb/tb_gf256_inv_sched.sv
// Directed + randomized bench for gf256_inv_sched; round-robin and fixed-priority
// instances share stimulus and are checked against a brute-force field-inverse model.
module tb_gf256_inv_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = 2'b00;
  logic [7:0] x0  = 8'h00;
  logic [7:0] x1  = 8'h00;
  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;

  gf256_inv_sched_if if_rr ();
  gf256_inv_sched_if if_fp ();

  assign if_rr.req = req;
  assign if_rr.x0  = x0;
  assign if_rr.x1  = x1;
  assign if_fp.req = req;
  assign if_fp.x0  = x0;
  assign if_fp.x1  = x1;

  gf256_inv_sched #(.RR(1'b1)) dut_rr (.clk(clk), .rst(rst), .bus(if_rr));
  gf256_inv_sched #(.RR(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(if_fp));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Carry-less product followed by long division by 0x11D.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011D << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] ref_inv(input logic [7:0] x);
    if (x == 8'h00) return 8'h00;
    for (int y = 1; y < 256; y++)
      if (gf_mul(x, 8'(y)) == 8'h01) return 8'(y);
    return 8'h00;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction from a single requester on the RR instance.
  task automatic inv(input int p, input logic [7:0] x);
    int g;
    int n;
    logic [7:0] ey;
    ey = ref_inv(x);
    @(negedge clk);
    if (p == 0) begin x0 = x; req[0] = 1'b1; end
    else begin x1 = x; req[1] = 1'b1; end
    #1;
    n = 0;
    while (if_rr.gnt == 2'b00 && n < 40) begin @(negedge clk); #1; n++; end
    check("grant", if_rr.gnt, (p != 0) ? 2'b10 : 2'b01);
    g = cyc;
    @(posedge clk);
    #1;
    req[p] = 1'b0;
    @(negedge clk);
    check("busy_in_flight", if_rr.busy, 1);
    n = 0;
    while (!if_rr.valid && n < 40) begin @(negedge clk); n++; end
    check("valid_seen", if_rr.valid, 1);
    check("latency", cyc - g - 1, 14);
    check("y", if_rr.y, ey);
    check("tag", if_rr.tag, p);
    check("zero", if_rr.zero, (x == 8'h00));
    check("busy_fall", if_rr.busy, 0);
    check("fp_y", if_fp.y, ey);
    if (x != 8'h00) check("x_times_y", gf_mul(x, if_rr.y), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   bad;
    int   n;
    int   nv;
    int   nf;
    int   prev;
    int   v1;
    logic [7:0] rx;
    int   rp;

    // Reset, asserted asynchronously before the first edge.
    #3 rst = 1'b1;
    #1;
    check("rst_valid", if_rr.valid, 0);
    check("rst_busy", if_rr.busy, 0);
    check("rst_tag", if_rr.tag, 0);
    check("rst_y", if_rr.y, 0);
    check("rst_zero", if_rr.zero, 0);
    check("rst_gnt", if_rr.gnt, 0);
    check("rst_fp_y", if_fp.y, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (if_rr.gnt !== 2'b00 || if_rr.busy !== 1'b0) bad = 1;
    end
    check("idle_after_reset", bad, 0);

    // Known inverses.
    inv(0, 8'h01); check("k01", if_rr.y, 8'h01);
    inv(0, 8'h02); check("k02", if_rr.y, 8'h8E);
    inv(0, 8'h03); check("k03", if_rr.y, 8'hF4);
    inv(0, 8'h53);

    // Zero operand, then a nonzero result clears the flag.
    inv(1, 8'h00);
    check("zero_y", if_rr.y, 8'h00);
    inv(0, 8'h05);
    check("zero_cleared", if_rr.zero, 0);

    // Arbitration: both hold requests; RR alternates, fixed priority serves 0.
    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
    x0 = 8'h02; x1 = 8'h03; req = 2'b11;
    #1;
    check("arb_first_rr", if_rr.gnt, 2'b01);
    check("arb_first_fp", if_fp.gnt, 2'b01);
    nv = 0; nf = 0; prev = -1; n = 0;
    while (nv < 4 && n < 120) begin
      @(negedge clk);
      n++;
      if (if_fp.valid) begin
        check("fp_tag", if_fp.tag, 0);
        check("fp_arb_y", if_fp.y, ref_inv(8'h02));
        nf++;
      end
      if (if_rr.valid) begin
        check("rr_tag", if_rr.tag, nv % 2);
        check("rr_y", if_rr.y, ref_inv((nv % 2 != 0) ? 8'h03 : 8'h02));
        if (prev >= 0) check("rr_spacing", cyc - prev, 15);
        prev = cyc;
        nv++;
        if (nv < 4) check("rr_next_gnt", if_rr.gnt, (nv % 2 != 0) ? 2'b10 : 2'b01);
        else req = 2'b00;
      end
    end
    check("rr_count", nv, 4);
    check("fp_count", nf, 4);

    // Request raised mid-computation: no grant until the valid cycle.
    @(negedge clk);
    x0 = 8'h07; req[0] = 1'b1;
    #1;
    check("b2b_gnt0", if_rr.gnt, 2'b01);
    @(posedge clk);
    #1 req[0] = 1'b0;
    repeat (3) @(negedge clk);
    x1 = 8'h09; req[1] = 1'b1;
    bad = 0; n = 0;
    @(negedge clk);
    while (!if_rr.valid && n < 40) begin
      if (if_rr.gnt !== 2'b00) bad = 1;
      @(negedge clk);
      n++;
    end
    check("b2b_no_gnt_busy", bad, 0);
    check("b2b_valid1", if_rr.valid, 1);
    check("b2b_gnt_in_valid", if_rr.gnt, 2'b10);
    check("b2b_y1", if_rr.y, ref_inv(8'h07));
    v1 = cyc;
    @(posedge clk);
    #1 req[1] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!if_rr.valid && n < 40) begin @(negedge clk); n++; end
    check("b2b_valid2", if_rr.valid, 1);
    check("b2b_spacing", cyc - v1, 15);
    check("b2b_y2", if_rr.y, ref_inv(8'h09));
    check("b2b_tag2", if_rr.tag, 1);

    // Reset in the middle of an inversion of 0x02.
    @(negedge clk);
    x0 = 8'h02; req[0] = 1'b1;
    #1;
    check("mid_gnt", if_rr.gnt, 2'b01);
    @(posedge clk);
    #1 req[0] = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_busy", if_rr.busy, 0);
    check("mid_y", if_rr.y, 0);
    check("mid_valid", if_rr.valid, 0);
    #2 rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (if_rr.valid !== 1'b0) bad = 1;
    end
    check("mid_no_valid", bad, 0);
    check("mid_y_after", if_rr.y, 0);
    inv(0, 8'h02);
    check("mid_reissue", if_rr.y, 8'h8E);

    // Randomized operands and ports.
    for (int k = 0; k < 24; k++) begin
      rx = 8'($urandom_range(0, 255));
      rp = int'($urandom_range(0, 1));
      inv(rp, rx);
    end

    // Exhaustive through both ports.
    for (int v = 0; v < 256; v++) begin
      inv(0, 8'(v));
      inv(1, 8'(v));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
